// File: rtl/daisy_chain_rr_scheduler.sv
// Round-robin scheduler built on a rotating daisy-chain priority arbiter.
// Registered one-hot grant with hold-limit preemption and an optional idle turn gap.
module daisy_chain_rr_scheduler #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 4,
    parameter int TURN_GAP = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic [0:N-1]         i_req,
    output logic [0:N-1]         o_gnt,
    output logic                 o_gnt_valid,
    output logic [$clog2(N)-1:0] o_gnt_id,
    output logic                 o_preempt
);

    localparam int PW = $clog2(N);
    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);
    localparam logic [PW-1:0] LAST_IDX   = PW'(N - 1);
    localparam logic [PW:0]   N_WIDE     = (PW + 1)'(N);

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        GAP
    } state_t;

    state_t        r_state;
    state_t        w_stateNext;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptrNext;
    logic [PW-1:0] r_owner;
    logic [PW-1:0] w_ownerNext;
    logic [HW-1:0] r_holdCnt;
    logic [HW-1:0] w_holdCntNext;
    logic          r_preempt;
    logic          w_preemptNext;

    logic [PW-1:0] w_ownerPlus1;
    logic [PW-1:0] w_arbPtr;
    logic [PW-1:0] w_winner;
    logic          w_found;
    logic          w_ownerReq;
    logic          w_expired;
    logic          w_handover;

    assign w_ownerPlus1 = (r_owner == LAST_IDX) ? '0 : r_owner + PW'(1);
    assign w_ownerReq   = i_req[r_owner];
    assign w_expired    = (MAX_HOLD != 0) && w_ownerReq && (r_holdCnt == HOLD_LIMIT);
    assign w_handover   = (r_state == OWN) && (!w_ownerReq || w_expired);

    // On handover the chain already starts at the successor of the departing owner, so a
    // preempted owner is scanned last and a releasing owner has its request bit clear anyway.
    assign w_arbPtr = w_handover ? w_ownerPlus1 : r_ptr;

    always_comb begin : daisyChain
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        sum      = '0;
        idx      = '0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = N - 1; i >= 0; i--) begin
            sum = {1'b0, w_arbPtr} + (PW + 1)'(i);
            if (sum >= N_WIDE) begin
                sum = sum - N_WIDE;
            end
            idx = sum[PW-1:0];
            if (i_req[idx]) begin
                w_found  = 1'b1;
                w_winner = idx;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_holdCnt <= '0;
            r_preempt <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_ptr     <= w_ptrNext;
            r_owner   <= w_ownerNext;
            r_holdCnt <= w_holdCntNext;
            r_preempt <= w_preemptNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_ptrNext     = r_ptr;
        w_ownerNext   = r_owner;
        w_holdCntNext = r_holdCnt;
        w_preemptNext = 1'b0;
        unique case (r_state)
            IDLE, GAP: begin
                w_stateNext = IDLE;
                if (i_en && w_found) begin
                    w_stateNext   = OWN;
                    w_ownerNext   = w_winner;
                    w_holdCntNext = HW'(1);
                end
            end
            OWN: begin
                if (w_handover) begin
                    w_ptrNext     = w_ownerPlus1;
                    w_preemptNext = w_expired;
                    w_holdCntNext = '0;
                    if (TURN_GAP != 0) begin
                        w_stateNext = GAP;
                    end else if (i_en && w_found) begin
                        w_stateNext   = OWN;
                        w_ownerNext   = w_winner;
                        w_holdCntNext = HW'(1);
                    end else begin
                        w_stateNext = IDLE;
                    end
                end else if ((MAX_HOLD != 0) && (r_holdCnt != HOLD_LIMIT)) begin
                    w_holdCntNext = r_holdCnt + HW'(1);
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_comb begin
        o_gnt       = '0;
        o_gnt_valid = (r_state == OWN);
        o_gnt_id    = '0;
        o_preempt   = r_preempt;
        if (r_state == OWN) begin
            o_gnt[r_owner] = 1'b1;
            o_gnt_id       = r_owner;
        end
    end

endmodule

// File: tb/tb_daisy_chain_rr_scheduler.sv
// Drives two scheduler configurations (hold limit 4 / back-to-back, unlimited / turn gap)
// with shared stimulus and compares both against an ownership-level reference model.
module tb_daisy_chain_rr_scheduler;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rstN;
    logic         en;
    logic [0:N-1] req;

    logic [0:N-1] dGnt   [2];
    logic         dValid [2];
    logic [2:0]   dId    [2];
    logic         dPre   [2];

    int cfgHold [2];
    int cfgGap  [2];
    int mOwner  [2];
    int mPtr    [2];
    int mHold   [2];
    bit mPre    [2];

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    daisy_chain_rr_scheduler #(.N(N), .MAX_HOLD(4), .TURN_GAP(0)) dutA (
        .i_clk(clk), .i_rst_n(rstN), .i_en(en), .i_req(req),
        .o_gnt(dGnt[0]), .o_gnt_valid(dValid[0]), .o_gnt_id(dId[0]), .o_preempt(dPre[0])
    );

    daisy_chain_rr_scheduler #(.N(N), .MAX_HOLD(0), .TURN_GAP(1)) dutB (
        .i_clk(clk), .i_rst_n(rstN), .i_en(en), .i_req(req),
        .o_gnt(dGnt[1]), .o_gnt_valid(dValid[1]), .o_gnt_id(dId[1]), .o_preempt(dPre[1])
    );

    function automatic int pickWinner(logic [0:N-1] r, int p);
        for (int j = 0; j < N; j++) begin
            if (r[(p + j) % N]) return (p + j) % N;
        end
        return -1;
    endfunction

    // Ownership-level model: an owner index (or -1), a priority origin and a hold count.
    function automatic void modelStep(int k);
        int w;
        bit released;
        bit expired;
        mPre[k] = 1'b0;
        if (!rstN) begin
            mOwner[k] = -1;
            mPtr[k]   = 0;
            mHold[k]  = 0;
            return;
        end
        if (mOwner[k] >= 0) begin
            released = !req[mOwner[k]];
            expired  = !released && cfgHold[k] != 0 && mHold[k] == cfgHold[k];
            if (!released && !expired) begin
                mHold[k]++;
                return;
            end
            mPre[k]   = expired;
            mPtr[k]   = (mOwner[k] + 1) % N;
            mOwner[k] = -1;
            if (cfgGap[k] != 0) return;
        end
        if (en) begin
            w = pickWinner(req, mPtr[k]);
            if (w >= 0) begin
                mOwner[k] = w;
                mHold[k]  = 1;
            end
        end
    endfunction

    function automatic logic [0:N-1] expGnt(int k);
        logic [0:N-1] g;
        g = '0;
        if (mOwner[k] >= 0) g[mOwner[k]] = 1'b1;
        return g;
    endfunction

    function automatic logic [2:0] expId(int k);
        return (mOwner[k] >= 0) ? 3'(mOwner[k]) : 3'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) modelStep(k);
        #1;
    endtask

    task automatic applyReset();
        rstN = 1'b0;
        en   = 1'b1;
        req  = '0;
        tick();
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        logic [0:N-1] first;
        first = 8'b10000000;
        rstN  = 1'b0;
        en    = 1'b1;
        req   = 8'b11111111;
        for (int c = 0; c < 2; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                testsRun++;
                if (dGnt[k] !== 8'b0 || dValid[k] !== 1'b0 || dPre[k] !== 1'b0 || dId[k] !== 3'd0) begin
                    testsFailed++;
                    $display("[TB] FAIL reset dut%0d cyc%0d: gnt=%b valid=%b pre=%b id=%0d, want all zero",
                             k, c, dGnt[k], dValid[k], dPre[k], dId[k]);
                end
            end
        end
        rstN = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            testsRun++;
            if (dGnt[k] !== first || dGnt[k] !== expGnt(k)) begin
                testsFailed++;
                $display("[TB] FAIL reset_release dut%0d: gnt=%b want %b", k, dGnt[k], first);
            end
        end
    endtask

    task automatic test_rotation();
        logic [0:N-1] pattern;
        applyReset();
        req = 8'b10101010;
        tick();
        for (int s = 0; s < 5; s++) begin
            testsRun++;
            if (dValid[0] !== 1'b1 || dId[0] !== 3'((2 * s) % N)) begin
                testsFailed++;
                $display("[TB] FAIL rotation step%0d: valid=%b id=%0d want owner %0d",
                         s, dValid[0], dId[0], (2 * s) % N);
            end
            for (int k = 0; k < 2; k++) begin
                testsRun++;
                if (dGnt[k] !== expGnt(k) || dId[k] !== expId(k) || dPre[k] !== mPre[k]) begin
                    testsFailed++;
                    $display("[TB] FAIL rotation_model dut%0d step%0d: gnt=%b id=%0d pre=%b want gnt=%b id=%0d pre=%b",
                             k, s, dGnt[k], dId[k], dPre[k], expGnt(k), expId(k), mPre[k]);
                end
            end
            pattern = 8'b10101010;
            pattern[(2 * s) % N] = 1'b0;
            req = pattern;
            tick();
        end
    endtask

    task automatic test_preemption();
        applyReset();
        req = 8'b11000000;
        for (int c = 0; c < 12; c++) begin
            tick();
            testsRun++;
            if (dId[0] !== 3'((c / 4) % 2) || dPre[0] !== (c > 0 && c % 4 == 0)) begin
                testsFailed++;
                $display("[TB] FAIL preemption cyc%0d: id=%0d pre=%b want id=%0d pre=%b",
                         c, dId[0], dPre[0], (c / 4) % 2, (c > 0 && c % 4 == 0));
            end
            for (int k = 0; k < 2; k++) begin
                testsRun++;
                if (dGnt[k] !== expGnt(k) || dPre[k] !== mPre[k]) begin
                    testsFailed++;
                    $display("[TB] FAIL preemption_model dut%0d cyc%0d: gnt=%b pre=%b want gnt=%b pre=%b",
                             k, c, dGnt[k], dPre[k], expGnt(k), mPre[k]);
                end
            end
        end
    endtask

    task automatic test_sole_requester();
        applyReset();
        req = 8'b00000001;
        for (int c = 0; c < 12; c++) begin
            tick();
            testsRun++;
            if (dGnt[0] !== 8'b00000001 || dPre[0] !== (c > 0 && c % 4 == 0)) begin
                testsFailed++;
                $display("[TB] FAIL sole_requester cyc%0d: gnt=%b pre=%b want gnt=00000001 pre=%b",
                         c, dGnt[0], dPre[0], (c > 0 && c % 4 == 0));
            end
            testsRun++;
            if (dGnt[1] !== 8'b00000001 || dPre[1] !== 1'b0 || dGnt[1] !== expGnt(1)) begin
                testsFailed++;
                $display("[TB] FAIL sole_unlimited cyc%0d: gnt=%b pre=%b want gnt=00000001 pre=0",
                         c, dGnt[1], dPre[1]);
            end
        end
    endtask

    task automatic test_gap_en();
        logic [0:N-1] reqSeq [6];
        logic         enSeq  [6];
        int           wantA  [6];
        int           wantB  [6];
        reqSeq = '{8'b00100000, 8'b00000100, 8'b00000100, 8'b00000110, 8'b00000010, 8'b00000010};
        enSeq  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        wantA  = '{2, 5, 5, 5, -1, -1};
        wantB  = '{2, -1, 5, 5, -1, -1};
        applyReset();
        for (int s = 0; s < 7; s++) begin
            req = (s < 6) ? reqSeq[s] : 8'b00000010;
            en  = (s < 6) ? enSeq[s] : 1'b1;
            tick();
            testsRun++;
            if (s < 6 && (dValid[0] !== (wantA[s] >= 0) || dValid[1] !== (wantB[s] >= 0) ||
                          (wantA[s] >= 0 && dId[0] !== 3'(wantA[s])) ||
                          (wantB[s] >= 0 && dId[1] !== 3'(wantB[s])))) begin
                testsFailed++;
                $display("[TB] FAIL gap_en step%0d: A valid=%b id=%0d B valid=%b id=%0d want A=%0d B=%0d",
                         s, dValid[0], dId[0], dValid[1], dId[1], wantA[s], wantB[s]);
            end else if (s == 6 && (dId[0] !== 3'd6 || dId[1] !== 3'd6 || dValid[0] !== 1'b1 || dValid[1] !== 1'b1)) begin
                testsFailed++;
                $display("[TB] FAIL gap_en_reenable: A id=%0d valid=%b B id=%0d valid=%b want 6",
                         dId[0], dValid[0], dId[1], dValid[1]);
            end
            for (int k = 0; k < 2; k++) begin
                testsRun++;
                if (dGnt[k] !== expGnt(k) || dPre[k] !== mPre[k]) begin
                    testsFailed++;
                    $display("[TB] FAIL gap_en_model dut%0d step%0d: gnt=%b pre=%b want gnt=%b pre=%b",
                             k, s, dGnt[k], dPre[k], expGnt(k), mPre[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_ownership();
        applyReset();
        req = 8'b00100000;
        tick();
        req = 8'b00010000;
        tick();
        tick();
        testsRun++;
        if (dId[0] !== 3'd3 || dId[1] !== 3'd3 || dValid[0] !== 1'b1 || dValid[1] !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset_setup: A id=%0d B id=%0d want 3", dId[0], dId[1]);
        end
        rstN = 1'b0;
        req  = 8'b01000010;
        tick();
        for (int k = 0; k < 2; k++) begin
            testsRun++;
            if (dGnt[k] !== 8'b0 || dPre[k] !== 1'b0 || dGnt[k] !== expGnt(k)) begin
                testsFailed++;
                $display("[TB] FAIL mid_reset_drop dut%0d: gnt=%b pre=%b want 0", k, dGnt[k], dPre[k]);
            end
        end
        rstN = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            testsRun++;
            if (dGnt[k] !== 8'b01000000 || dId[k] !== 3'd1 || dGnt[k] !== expGnt(k)) begin
                testsFailed++;
                $display("[TB] FAIL mid_reset_regrant dut%0d: gnt=%b id=%0d want 01000000 id=1",
                         k, dGnt[k], dId[k]);
            end
        end
    endtask

    task automatic test_random();
        applyReset();
        req = '0;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(3) == 0) req[b] = ~req[b];
            end
            en   = ($urandom_range(3) != 0);
            rstN = ($urandom_range(59) != 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                testsRun++;
                if (dGnt[k] !== expGnt(k) || dValid[k] !== (mOwner[k] >= 0) ||
                    dId[k] !== expId(k) || dPre[k] !== mPre[k]) begin
                    testsFailed++;
                    $display("[TB] FAIL random dut%0d cyc%0d: gnt=%b valid=%b id=%0d pre=%b want gnt=%b id=%0d pre=%b",
                             k, c, dGnt[k], dValid[k], dId[k], dPre[k], expGnt(k), expId(k), mPre[k]);
                end
            end
        end
        rstN = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cfgHold = '{4, 0};
        cfgGap  = '{0, 1};
        mOwner  = '{-1, -1};
        mPtr    = '{0, 0};
        mHold   = '{0, 0};
        mPre    = '{1'b0, 1'b0};
        rstN    = 1'b0;
        en      = 1'b1;
        req     = '0;
        test_reset();
        test_rotation();
        test_preemption();
        test_sole_requester();
        test_gap_en();
        test_reset_mid_ownership();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
